div3_request_scheduler: RTL

Sequencing controller for the shared 20-bit divide-by-3 shift-register datapath. It takes divide requests from NREQ requesters through a round-robin arbiter and loads the winner's dividend into the datapath. It then counts the nibble-serial steps and captures the quotient and remainder before the datapath's free-running shift corrupts them. The result is returned to the requester through a valid/ready response port tagged with its requester ID.

---
 rtl/div3_pkg.sv | 22 ++
 rtl/div3_rr_arbiter.sv | 31 +++
 rtl/div3_request_scheduler.sv | 119 +++++++++++
 3 files changed

// File: rtl/div3_pkg.sv
// Shared types and sizing helpers for the divide-by-3 request scheduler.
package div3_pkg;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_CAPT = 3'd3,
        S_RESP = 3'd4
    } div3_sched_state_t;

    function automatic int unsigned div3_steps(input int unsigned size);
        return size / 4;
    endfunction

    function automatic int unsigned div3_cnt_w(input int unsigned size, input int unsigned pipe_lat);
        return $clog2(size / 4 + pipe_lat + 1);
    endfunction

    localparam int unsigned DIV3_CNT_W = div3_cnt_w(20, 0);

endpackage

// File: rtl/div3_rr_arbiter.sv
// Combinational round-robin pick: first active request after last_grant, wrapping modulo NREQ.
module div3_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    output logic [IDW-1:0]  winner,
    output logic            valid
);

    logic [IDW:0] w_idx;

    always_comb begin
        winner = '0;
        w_idx  = '0;
        // Walk from the farthest offset to the nearest so the nearest active requester wins.
        for (int unsigned i = NREQ; i >= 1; i--) begin
            w_idx = {1'b0, last_grant} + (IDW+1)'(i);
            if (w_idx >= (IDW+1)'(NREQ)) begin
                w_idx = w_idx - (IDW+1)'(NREQ);
            end
            if (req[w_idx[IDW-1:0]]) begin
                winner = w_idx[IDW-1:0];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/div3_request_scheduler.sv
// Arbitrates divide requests, sequences the shared divide-by-3 datapath and returns
// the captured result on a valid/ready response port tagged with the requester ID.
module div3_request_scheduler
    import div3_pkg::*;
#(
    parameter int unsigned SIZE     = 20,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned PIPE_LAT = 0
) (
    input  logic                     sys_clock,
    input  logic                     reset_n,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*SIZE-1:0]     req_dividend,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     div_shift_en,
    output logic [SIZE-1:0]          div_divident,
    input  logic [SIZE-1:0]          div_quotient,
    input  logic [1:0]               div_reminder,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [SIZE-1:0]          rsp_quotient,
    output logic [1:0]               rsp_reminder
);

    localparam int unsigned STEPS   = div3_steps(SIZE);
    localparam int unsigned RUN_LEN = STEPS + PIPE_LAT;
    localparam int unsigned CNT_W   = div3_cnt_w(SIZE, PIPE_LAT);
    localparam int unsigned IDW     = $clog2(NREQ);

    div3_sched_state_t r_state;
    logic [IDW-1:0]    r_id;
    logic [IDW-1:0]    r_last_grant;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_shift_en;
    logic [SIZE-1:0]   r_divident;
    logic [IDW-1:0]    r_rsp_id;
    logic [SIZE-1:0]   r_rsp_quotient;
    logic [1:0]        r_rsp_reminder;

    logic [IDW-1:0]    w_winner;
    logic              w_arb_valid;
    logic [SIZE-1:0]   w_dividends [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_div_slice
        assign w_dividends[g] = req_dividend[g*SIZE +: SIZE];
    end

    div3_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req),
        .last_grant (r_last_grant),
        .winner     (w_winner),
        .valid      (w_arb_valid)
    );

    always_ff @(posedge sys_clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_id           <= '0;
            r_last_grant   <= IDW'(NREQ - 1);
            r_cnt          <= '0;
            r_shift_en     <= 1'b0;
            r_divident     <= '0;
            r_rsp_id       <= '0;
            r_rsp_quotient <= '0;
            r_rsp_reminder <= '0;
        end else begin
            r_shift_en <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_arb_valid) begin
                        r_id       <= w_winner;
                        r_divident <= w_dividends[w_winner];
                        r_shift_en <= 1'b1;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_last_grant <= r_id;
                    r_cnt        <= '0;
                    r_state      <= S_RUN;
                end
                S_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(RUN_LEN - 1)) begin
                        r_state <= S_CAPT;
                    end
                end
                S_CAPT: begin
                    // Datapath result is valid only in this cycle; it keeps shifting afterwards.
                    r_rsp_quotient <= div_quotient;
                    r_rsp_reminder <= div_reminder;
                    r_rsp_id       <= r_id;
                    r_state        <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant        = (r_state == S_LOAD) ? (NREQ'(1) << r_id) : '0;
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign div_shift_en = r_shift_en;
    assign div_divident = r_divident;
    assign rsp_id       = r_rsp_id;
    assign rsp_quotient = r_rsp_quotient;
    assign rsp_reminder = r_rsp_reminder;

endmodule
